// File: rtl/assoc_search_unit.sv
// -----------------------------------------------------------------------------
// assoc_search_unit
//
// Sequential associative-search engine for a 2^AWIDTH-word store. An accepted
// START latches a key and an inclusive address window [BASE..LAST]. The engine
// then reads the store one word at a time through a synchronous read port
// (data returns the cycle after RD_EN) and compares each word against the key
// using full-width equality. The first match in scan order is reported. If
// nothing matches, not-found is reported. Either result comes with a
// one-cycle DONE pulse. A window with LAST < BASE wraps through the top of
// the address space.
//
// Ports
//   CLK         system clock, all state changes on the rising edge
//   RST         synchronous reset, active-high
//   START       begin a search (sampled only in IDLE)
//   ABORT       cancel a search in progress (FETCH or COMPARE)
//   KEY         search key, latched on accepted START
//   BASE        first address of the window, latched on accepted START
//   LAST        final address of the window (inclusive), latched on START
//   RD_EN       store read strobe
//   RD_ADDR     store read address (holds while RD_EN is low)
//   RD_DATA     store read data, valid the cycle after RD_EN
//   BUSY        high while in FETCH or COMPARE
//   DONE        one-cycle completion pulse
//   FOUND       result flag, match found
//   MATCH_ADDR  address of the first match
// -----------------------------------------------------------------------------
module assoc_search_unit #(
   parameter int WIDTH  = 8,
   parameter int AWIDTH = 9
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic [WIDTH-1:0]  KEY,
   input  logic [AWIDTH-1:0] BASE,
   input  logic [AWIDTH-1:0] LAST,
   output logic              RD_EN,
   output logic [AWIDTH-1:0] RD_ADDR,
   input  logic [WIDTH-1:0]  RD_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              FOUND,
   output logic [AWIDTH-1:0] MATCH_ADDR
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_COMPARE = 2'd2,
      ST_FINISH  = 2'd3
   } state_t;

   // The equality comparator driven by this engine: every bit must agree.
   function automatic logic key_equal(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
      key_equal = (a == b);
   endfunction

   localparam logic [AWIDTH-1:0] ADDR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
   localparam logic [AWIDTH-1:0] ADDR_ZERO = {AWIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  KEY_ZERO  = {WIDTH{1'b0}};

   state_t            state_r, state_nxt_s;
   logic [WIDTH-1:0]  key_r, key_nxt_s;
   logic [AWIDTH-1:0] last_r, last_nxt_s;
   // Current scan address; it is also the read address presented to the store,
   // so it naturally holds while RD_EN is low.
   logic [AWIDTH-1:0] addr_r, addr_nxt_s;
   logic              rd_en_r, rd_en_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic              done_r, done_nxt_s;
   logic              found_r, found_nxt_s;
   logic [AWIDTH-1:0] match_addr_r, match_addr_nxt_s;

   // Next-state and next-output decode; all outputs are registered from these.
   always_comb begin
      state_nxt_s      = state_r;
      key_nxt_s        = key_r;
      last_nxt_s       = last_r;
      addr_nxt_s       = addr_r;
      rd_en_nxt_s      = 1'b0;
      busy_nxt_s       = 1'b0;
      done_nxt_s       = 1'b0;
      found_nxt_s      = found_r;
      match_addr_nxt_s = match_addr_r;

      case (state_r)
         ST_IDLE: begin
            // START beats a simultaneous ABORT; ABORT is meaningless here.
            if (START) begin
               key_nxt_s        = KEY;
               last_nxt_s       = LAST;
               addr_nxt_s       = BASE;
               found_nxt_s      = 1'b0;
               match_addr_nxt_s = ADDR_ZERO;
               rd_en_nxt_s      = 1'b1;
               busy_nxt_s       = 1'b1;
               state_nxt_s      = ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_FETCH: begin
            if (ABORT) begin
               state_nxt_s = ST_IDLE;
            end else begin
               busy_nxt_s  = 1'b1;
               state_nxt_s = ST_COMPARE;
            end
         end

         ST_COMPARE: begin
            // ABORT wins even when the word just returned matches.
            if (ABORT) begin
               state_nxt_s = ST_IDLE;
            end else if (key_equal(RD_DATA, key_r)) begin
               found_nxt_s      = 1'b1;
               match_addr_nxt_s = addr_r;
               done_nxt_s       = 1'b1;
               state_nxt_s      = ST_FINISH;
            end else if (addr_r == last_r) begin
               found_nxt_s = 1'b0;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_FINISH;
            end else begin
               // Natural AWIDTH-bit overflow gives the wrap to address 0.
               addr_nxt_s  = addr_r + ADDR_ONE;
               rd_en_nxt_s = 1'b1;
               busy_nxt_s  = 1'b1;
               state_nxt_s = ST_FETCH;
            end
         end

         ST_FINISH: begin
            state_nxt_s = ST_IDLE;
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r      <= ST_IDLE;
         key_r        <= KEY_ZERO;
         last_r       <= ADDR_ZERO;
         addr_r       <= ADDR_ZERO;
         rd_en_r      <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         found_r      <= 1'b0;
         match_addr_r <= ADDR_ZERO;
      end else begin
         state_r      <= state_nxt_s;
         key_r        <= key_nxt_s;
         last_r       <= last_nxt_s;
         addr_r       <= addr_nxt_s;
         rd_en_r      <= rd_en_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         found_r      <= found_nxt_s;
         match_addr_r <= match_addr_nxt_s;
      end
   end

   assign RD_EN      = rd_en_r;
   assign RD_ADDR    = addr_r;
   assign BUSY       = busy_r;
   assign DONE       = done_r;
   assign FOUND      = found_r;
   assign MATCH_ADDR = match_addr_r;

   assoc_search_unit_chk u_chk (
      .clk   (CLK),
      .rst   (RST),
      .busy  (busy_r),
      .rd_en (rd_en_r),
      .done  (done_r)
   );

endmodule

// -----------------------------------------------------------------------------
// assoc_search_unit_chk
//
// Protocol properties of the search engine outputs.
// Ports
//   clk, rst   clock and synchronous reset of the engine
//   busy       engine BUSY output
//   rd_en      engine RD_EN output
//   done       engine DONE output
// -----------------------------------------------------------------------------
module assoc_search_unit_chk (
   input logic clk,
   input logic rst,
   input logic busy,
   input logic rd_en,
   input logic done
);

   // A read strobe only occurs while a search is in progress.
   rd_en_busy_a : assert property (@(posedge clk) disable iff (rst)
      rd_en |-> busy);

   // Completion is reported outside the busy window.
   done_not_busy_a : assert property (@(posedge clk) disable iff (rst)
      done |-> !busy);

   // DONE is a single-cycle pulse.
   done_pulse_a : assert property (@(posedge clk) disable iff (rst)
      done |=> !done);

endmodule

// File: tb/tb_assoc_search_unit.sv
module tb_assoc_search_unit;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [7:0] KEY = 8'h00;
   logic [8:0] BASE = 9'h000;
   logic [8:0] LAST = 9'h000;
   logic       RD_EN;
   logic [8:0] RD_ADDR;
   logic [7:0] RD_DATA = 8'h00;
   logic       BUSY;
   logic       DONE;
   logic       FOUND;
   logic [8:0] MATCH_ADDR;

   int checks = 0;
   int errors = 0;

   // Store model: synchronous read port plus a read counter/last-address log.
   logic [7:0] mem [0:511];
   int         rd_cnt = 0;
   logic [8:0] last_rd = 9'h000;

   assoc_search_unit #(.WIDTH(8), .AWIDTH(9)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .ABORT      (ABORT),
      .KEY        (KEY),
      .BASE       (BASE),
      .LAST       (LAST),
      .RD_EN      (RD_EN),
      .RD_ADDR    (RD_ADDR),
      .RD_DATA    (RD_DATA),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .FOUND      (FOUND),
      .MATCH_ADDR (MATCH_ADDR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RD_EN) begin
         RD_DATA <= mem[RD_ADDR];
         rd_cnt  <= rd_cnt + 1;
         last_rd <= RD_ADDR;
      end
   end

   typedef struct {
      logic [8:0] a1;
      logic [7:0] d1;
      logic [8:0] a2;
      logic [7:0] d2;
      logic [7:0] key;
      logic [8:0] base;
      logic [8:0] last;
      logic       exp_found;
      logic [8:0] exp_match;
      int         exp_cyc;
      int         exp_reads;
      logic [8:0] exp_last_rd;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
   endtask

   // Present a START at a negedge; returns just after the accepting edge.
   task automatic launch(input logic [7:0] k, input logic [8:0] b,
                         input logic [8:0] l, output int rd0);
      @(negedge CLK);
      KEY = k; BASE = b; LAST = l; START = 1'b1;
      rd0 = rd_cnt;
      @(posedge CLK);
   endtask

   // Starting from cycle c_now (already sampled), find the first DONE cycle.
   task automatic wait_done(input int c_now, input int limit, output int cyc);
      int c;
      c = c_now;
      while (DONE !== 1'b1 && c < limit) begin
         @(negedge CLK);
         c++;
      end
      cyc = (DONE === 1'b1) ? c : -1;
   endtask

   initial begin
      int rd0;
      int cyc;
      string nm;

      vecs[0] = '{9'h010, 8'h5A, 9'h000, 8'h00, 8'h5A, 9'h00C, 9'h01F, 1'b1, 9'h010,   11,   5, 9'h010};
      vecs[1] = '{9'h000, 8'h00, 9'h000, 8'h00, 8'hFF, 9'h000, 9'h003, 1'b0, 9'h000,    9,   4, 9'h003};
      vecs[2] = '{9'h1FF, 8'h33, 9'h001, 8'h33, 8'h33, 9'h1FE, 9'h002, 1'b1, 9'h1FF,    5,   2, 9'h1FF};
      vecs[3] = '{9'h001, 8'h33, 9'h000, 8'h00, 8'h33, 9'h1FE, 9'h002, 1'b1, 9'h001,    9,   4, 9'h001};
      vecs[4] = '{9'h000, 8'h00, 9'h000, 8'h00, 8'h77, 9'h055, 9'h055, 1'b0, 9'h000,    3,   1, 9'h055};
      vecs[5] = '{9'h055, 8'h77, 9'h000, 8'h00, 8'h77, 9'h055, 9'h055, 1'b1, 9'h055,    3,   1, 9'h055};
      vecs[6] = '{9'h020, 8'hDA, 9'h021, 8'h5A, 8'h5A, 9'h020, 9'h022, 1'b1, 9'h021,    5,   2, 9'h021};
      vecs[7] = '{9'h000, 8'h00, 9'h000, 8'h00, 8'h01, 9'h080, 9'h07F, 1'b0, 9'h000, 1025, 512, 9'h07F};
      vecs[8] = '{9'h000, 8'h00, 9'h000, 8'h00, 8'h00, 9'h100, 9'h1FF, 1'b1, 9'h100,    3,   1, 9'h100};

      clear_mem();

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_rd_en", RD_EN, 0);
      check("rst_done", DONE, 0);
      check("rst_found", FOUND, 0);
      check("rst_rd_addr", RD_ADDR, 0);
      check("rst_match", MATCH_ADDR, 0);
      RST = 1'b0;

      // Table-driven searches
      for (int v = 0; v < 9; v++) begin
         clear_mem();
         mem[vecs[v].a1] = vecs[v].d1;
         if (vecs[v].d2 != 8'h00) mem[vecs[v].a2] = vecs[v].d2;
         launch(vecs[v].key, vecs[v].base, vecs[v].last, rd0);
         @(negedge CLK);
         START = 1'b0;
         // Scrambling the inputs mid-search must not matter.
         KEY = ~vecs[v].key; BASE = 9'h0AA; LAST = 9'h0AB;
         nm = $sformatf("v%0d", v);
         check({nm, "_rd_en_c1"}, RD_EN, 1);
         check({nm, "_rd_addr_c1"}, RD_ADDR, vecs[v].base);
         check({nm, "_busy_c1"}, BUSY, 1);
         wait_done(1, 1200, cyc);
         check({nm, "_done_cycle"}, cyc, vecs[v].exp_cyc);
         check({nm, "_found"}, FOUND, vecs[v].exp_found);
         check({nm, "_match"}, MATCH_ADDR, vecs[v].exp_match);
         check({nm, "_busy_fin"}, BUSY, 0);
         check({nm, "_reads"}, rd_cnt - rd0, vecs[v].exp_reads);
         check({nm, "_last_rd"}, last_rd, vecs[v].exp_last_rd);
         @(negedge CLK);
         check({nm, "_done_pulse"}, DONE, 0);
         check({nm, "_found_hold"}, FOUND, vecs[v].exp_found);
         check({nm, "_match_hold"}, MATCH_ADDR, vecs[v].exp_match);
      end

      // ABORT in the COMPARE cycle of a matching word
      clear_mem();
      mem[9'h040] = 8'h99;
      launch(8'h99, 9'h040, 9'h045, rd0);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      check("abort_busy", BUSY, 0);
      check("abort_rd_en", RD_EN, 0);
      check("abort_done", DONE, 0);
      check("abort_found", FOUND, 0);
      wait_done(3, 14, cyc);
      check("abort_no_done", cyc, -1);
      check("abort_reads", rd_cnt - rd0, 1);

      // Second START during BUSY is ignored
      clear_mem();
      mem[9'h010] = 8'h5A;
      launch(8'h5A, 9'h00C, 9'h01F, rd0);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      START = 1'b1; KEY = 8'h00; BASE = 9'h000; LAST = 9'h000;
      @(negedge CLK);
      START = 1'b0;
      wait_done(3, 40, cyc);
      check("restart_done_cycle", cyc, 11);
      check("restart_found", FOUND, 1);
      check("restart_match", MATCH_ADDR, 9'h010);
      check("restart_reads", rd_cnt - rd0, 5);

      // RST during FETCH
      launch(8'h5A, 9'h00C, 9'h01F, rd0);
      @(negedge CLK);
      START = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_mid_busy", BUSY, 0);
      check("rst_mid_rd_en", RD_EN, 0);
      check("rst_mid_found", FOUND, 0);
      check("rst_mid_match", MATCH_ADDR, 0);
      check("rst_mid_rd_addr", RD_ADDR, 0);
      wait_done(2, 16, cyc);
      check("rst_mid_no_done", cyc, -1);

      // START with ABORT in IDLE, then START held across FINISH->IDLE
      clear_mem();
      mem[9'h055] = 8'h77;
      @(negedge CLK);
      KEY = 8'h77; BASE = 9'h055; LAST = 9'h055; START = 1'b1; ABORT = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ABORT = 1'b0;
      check("startabort_busy", BUSY, 1);
      wait_done(1, 10, cyc);
      check("held_done1", cyc, 3);
      @(negedge CLK);
      check("held_idle_busy", BUSY, 0);
      check("held_idle_done", DONE, 0);
      @(negedge CLK);
      check("held_rd_en", RD_EN, 1);
      check("held_busy", BUSY, 1);
      START = 1'b0;
      wait_done(5, 14, cyc);
      check("held_done2", cyc, 7);
      check("held_found", FOUND, 1);
      check("held_match", MATCH_ADDR, 9'h055);

      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/assoc_search_unit.md
Name: assoc_search_unit

Overview:
- Sequential associative-search engine for the 512-word store. It is the initiator that drives the equality comparator.
- On START it latches a key and an address window. It then reads store words one at a time through a synchronous read port and compares each against the key.
- It reports the first matching address, or not-found, with a one-cycle DONE pulse.
- Used by the control unit for tag/key lookup instructions.

Parameters:
- WIDTH, 8, data/key word width in bits
- AWIDTH, 9, store address width (512 words)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  begin search; sampled only in IDLE
- ABORT  in  1  cancel a search in progress
- KEY  in  WIDTH  search key; latched on accepted START
- BASE  in  AWIDTH  first address to examine; latched on accepted START
- LAST  in  AWIDTH  final address to examine, inclusive; latched on accepted START
- RD_EN  out  1  store read strobe
- RD_ADDR  out  AWIDTH  store read address
- RD_DATA  in  WIDTH  store read data; valid the cycle after RD_EN
- BUSY  out  1  high while a search is in progress (FETCH or COMPARE)
- DONE  out  1  one-cycle completion pulse
- FOUND  out  1  result flag: match found
- MATCH_ADDR  out  AWIDTH  address of the first match

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RST).
- Reset values:
  - state = IDLE
  - RD_EN, BUSY, DONE, FOUND = 0
  - RD_ADDR, MATCH_ADDR = 0
  - latched KEY/BASE/LAST registers = 0
- States:
  - IDLE: waits for START.
  - FETCH: RD_EN=1, RD_ADDR=current address.
  - COMPARE: RD_EN=0. Compare RD_DATA against the latched key; the comparison is the full-width equality.
  - FINISH: DONE=1 for exactly one cycle.
- Transitions:
  - IDLE, START=1 -> latch KEY/BASE/LAST; current address := BASE; go to FETCH.
  - FETCH -> COMPARE.
  - COMPARE, match -> FOUND:=1, MATCH_ADDR:=current address, go to FINISH.
  - COMPARE, no match, current address == LAST -> FOUND:=0, go to FINISH.
  - COMPARE, otherwise -> current address := (current + 1) mod 2^AWIDTH, go to FETCH.
  - FINISH -> IDLE.
- Timing: START sampled at edge k gives RD_EN in cycle k+1 and compare in cycle k+2.
  - Match at window index i (0-based): DONE high in cycle 2i+3 after edge k.
  - Full window of N words with no match: DONE in cycle 2N+1.
- Priority: the first match in scan order wins. Later matches are never examined.
- Wrap-around: if LAST < BASE, the scan runs BASE..2^AWIDTH-1, then 0..LAST.
  - BASE == LAST examines exactly one word.
  - Maximum window is 2^AWIDTH words (LAST = BASE-1 mod 2^AWIDTH).
- FOUND/MATCH_ADDR:
  - Cleared to 0 on an accepted START.
  - Updated at FINISH.
  - Held stable in IDLE until the next accepted START.
- START behaviour:
  - START while BUSY or in FINISH is ignored.
  - KEY/BASE/LAST changing mid-search has no effect.
  - START held high across FINISH->IDLE starts a new search on the first IDLE cycle.
- ABORT:
  - ABORT=1 in FETCH or COMPARE -> IDLE next edge; DONE=0, FOUND=0, RD_EN=0.
  - ABORT has priority over a same-cycle match.
  - ABORT in IDLE/FINISH has no effect; FINISH still pulses DONE.
  - ABORT and START together in IDLE: START wins.
- RST mid-search -> all outputs to reset values next edge. No DONE pulse is generated.
- BUSY = 1 exactly in FETCH and COMPARE.
- RD_ADDR holds its last value when RD_EN=0.

Test Plan:
- Store[0x10]=0x5A, others 0x00; KEY=0x5A, BASE=0x0C, LAST=0x1F, START pulse -> RD_EN strobes on 0x0C..0x10; DONE in cycle 11 after the START edge; FOUND=1, MATCH_ADDR=0x10; no read of 0x11.
- Store all 0x00; KEY=0xFF, BASE=0x000, LAST=0x003 -> four reads; DONE at cycle 9; FOUND=0; MATCH_ADDR=0.
- Store[0x1FF]=0x33, Store[0x001]=0x33; BASE=0x1FE, LAST=0x002, KEY=0x33 -> reads 0x1FE then 0x1FF; FOUND=1, MATCH_ADDR=0x1FF; address 0x000 never read.
- Wrap to low end: Store[0x001]=0x33 only; BASE=0x1FE, LAST=0x002 -> reads 0x1FE, 0x1FF, 0x000, 0x001; MATCH_ADDR=0x001.
- Same-cycle ABORT: start a search matching at BASE; assert ABORT in the COMPARE cycle -> IDLE next edge; DONE never pulses; FOUND=0.
- Same-cycle START: second START during BUSY is ignored. RST asserted during FETCH -> next edge BUSY=0, RD_EN=0, FOUND=0, MATCH_ADDR=0, no DONE pulse.
